// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio widths, note half-period divisors and sample saturation
package audio_pkg;

  localparam int DIV_W    = 22;
  localparam int SAMPLE_W = 16;

  // Octave-4 half periods in 50 MHz clock cycles; each lower octave doubles them.
  function automatic logic [DIV_W-1:0] note_div(input int octave, input int semi);
    int half;
    case (semi)
      0:       half = 95556;
      1:       half = 90194;
      2:       half = 85133;
      3:       half = 80353;
      4:       half = 75843;
      5:       half = 71586;
      6:       half = 67569;
      7:       half = 63776;
      8:       half = 60197;
      9:       half = 56818;
      10:      half = 53630;
      default: half = 50620;
    endcase
    return DIV_W'((half << (4 - octave)) - 1);
  endfunction

  localparam logic [DIV_W-1:0] REST = '0;
  localparam logic [DIV_W-1:0] C2 = note_div(2, 0), CS2 = note_div(2, 1), D2 = note_div(2, 2),
    DS2 = note_div(2, 3), E2 = note_div(2, 4), F2 = note_div(2, 5), FS2 = note_div(2, 6),
    G2 = note_div(2, 7), GS2 = note_div(2, 8), A2 = note_div(2, 9), AS2 = note_div(2, 10),
    B2 = note_div(2, 11);
  localparam logic [DIV_W-1:0] C3 = note_div(3, 0), CS3 = note_div(3, 1), D3 = note_div(3, 2),
    DS3 = note_div(3, 3), E3 = note_div(3, 4), F3 = note_div(3, 5), FS3 = note_div(3, 6),
    G3 = note_div(3, 7), GS3 = note_div(3, 8), A3 = note_div(3, 9), AS3 = note_div(3, 10),
    B3 = note_div(3, 11);
  localparam logic [DIV_W-1:0] C4 = note_div(4, 0), CS4 = note_div(4, 1), D4 = note_div(4, 2),
    DS4 = note_div(4, 3), E4 = note_div(4, 4), F4 = note_div(4, 5), FS4 = note_div(4, 6),
    G4 = note_div(4, 7), GS4 = note_div(4, 8), A4 = note_div(4, 9), AS4 = note_div(4, 10),
    B4 = note_div(4, 11);

  function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [31:0] x);
    if (x > 32'sd32767)
      return 16'sh7fff;
    else if (x < -32'sd32768)
      return 16'sh8000;
    else
      return x[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/tone_channel.sv
// rtl/tone_channel.sv - one square-wave voice: divisor register, period counter, phase and signed sample
module tone_channel #(
  parameter int DIV_W    = 22,
  parameter int SAMPLE_W = 18
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_i,
  input  logic [DIV_W-1:0]           div_i,
  input  logic signed [SAMPLE_W-1:0] amp_i,
  output logic signed [SAMPLE_W-1:0] sample_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // A new pitch restarts the count but keeps the waveform's phase running.
  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (load_i && div_i != div_q) begin
      div_d = div_i;
      cnt_d = '0;
      if (div_i == '0 || div_q == '0)
        phase_d = 1'b0;
      else if (cnt_q == div_q)
        phase_d = ~phase_q;
    end else if (div_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == div_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  assign sample_o = (div_q == '0) ? '0 : (phase_q ? amp_i : -amp_i);

endmodule

// File: rtl/poly_tone_sequencer.sv
// rtl/poly_tone_sequencer.sv - multi-channel note table sequencer with volume control and saturating mixer
module poly_tone_sequencer
  import audio_pkg::saturate;
#(
  parameter int NUM_CH    = 2,
  parameter int SEQ_DEPTH = 80,
  parameter int DIV_W     = audio_pkg::DIV_W,
  parameter int VOL_W     = 4,
  parameter int AMP_UNIT  = 1024,
  parameter int STEREO    = 0,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int IDX_W    = (SEQ_DEPTH > 1) ? $clog2(SEQ_DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_tick,
  input  logic                play_en,
  input  logic                loop_mode,
  input  logic                restart,
  input  logic                vol_up,
  input  logic                vol_down,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [IDX_W-1:0]    wr_addr,
  input  logic [DIV_W-1:0]    wr_div,
  output logic signed [15:0]  audio_left,
  output logic signed [15:0]  audio_right,
  output logic [VOL_W-1:0]    vol,
  output logic [IDX_W-1:0]    step_idx,
  output logic                done
);

  localparam int SUM_W = 16 + $clog2(NUM_CH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_DEPTH - 1);
  localparam logic [VOL_W-1:0] VOL_MAX  = '1;
  localparam logic [VOL_W-1:0] VOL_RST  = VOL_W'(1 << (VOL_W - 1));

  logic [DIV_W-1:0] table_q [NUM_CH][SEQ_DEPTH];

  logic [IDX_W-1:0] step_idx_q, step_idx_d;
  logic             done_q, done_d;
  logic [VOL_W-1:0] vol_q, vol_d;
  logic signed [15:0] left_q, right_q;

  logic                    adv, load, clear;
  logic [DIV_W-1:0]        ch_div [NUM_CH];
  logic signed [SUM_W-1:0] amp;
  logic signed [SUM_W-1:0] sample [NUM_CH];
  logic signed [SUM_W-1:0] sum_l, sum_r;

  // Non-blocking write keeps the same-cycle read on the old contents.
  always_ff @(posedge clk) begin
    if (wr_en)
      table_q[wr_ch][wr_addr] <= wr_div;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_idx_q <= '0;
      done_q     <= 1'b0;
      vol_q      <= VOL_RST;
      left_q     <= '0;
      right_q    <= '0;
    end else begin
      step_idx_q <= step_idx_d;
      done_q     <= done_d;
      vol_q      <= vol_d;
      left_q     <= saturate(32'(sum_l));
      right_q    <= saturate(32'(sum_r));
    end
  end

  assign adv = step_tick & play_en & ~restart;

  // The first tick after a one-shot run finishes silences the held last note.
  always_comb begin
    step_idx_d = step_idx_q;
    done_d     = done_q;
    load       = 1'b0;
    clear      = 1'b0;
    if (restart) begin
      step_idx_d = '0;
      done_d     = 1'b0;
      clear      = 1'b1;
    end else if (adv && done_q) begin
      clear = 1'b1;
    end else if (adv) begin
      load = 1'b1;
      if (step_idx_q == LAST_IDX) begin
        if (loop_mode)
          step_idx_d = '0;
        else
          done_d = 1'b1;
      end else begin
        step_idx_d = step_idx_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    vol_d = vol_q;
    if (vol_up && !vol_down && vol_q != VOL_MAX)
      vol_d = vol_q + VOL_W'(1);
    else if (vol_down && !vol_up && vol_q != '0)
      vol_d = vol_q - VOL_W'(1);
  end

  assign amp = SUM_W'(int'(vol_q) * AMP_UNIT);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_div[c] = clear ? '0 : table_q[c][step_idx_q];

    tone_channel #(
      .DIV_W    (DIV_W),
      .SAMPLE_W (SUM_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load | clear),
      .div_i    (ch_div[c]),
      .amp_i    (amp),
      .sample_o (sample[c])
    );
  end

  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (STEREO == 0 || (c % 2) == 0)
        sum_l = sum_l + sample[c];
      if (STEREO == 0 || (c % 2) == 1)
        sum_r = sum_r + sample[c];
    end
  end

  assign audio_left  = left_q;
  assign audio_right = right_q;
  assign vol         = vol_q;
  assign step_idx    = step_idx_q;
  assign done        = done_q;

endmodule

// File: tb/tb_poly_tone_sequencer.sv
// tb/tb_poly_tone_sequencer.sv - self-checking bench: three configurations against a closed-form model
module tb_poly_tone_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step_tick = 0, play_en = 1, loop_mode = 1, restart = 0;
  logic vol_up = 0, vol_down = 0, wr_en = 0;
  logic wr_ch = 0;
  logic [1:0] wr_addr = 0;
  logic [21:0] wr_div = 0;

  logic signed [15:0] l0, r0, l1, r1, l2, r2;
  logic [3:0] vol0, vol1, vol2;
  logic [1:0] idx0, idx1, idx2;
  logic done0, done1, done2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  poly_tone_sequencer #(.NUM_CH(2), .SEQ_DEPTH(3), .DIV_W(22), .VOL_W(4), .AMP_UNIT(1024), .STEREO(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .step_tick(step_tick), .play_en(play_en), .loop_mode(loop_mode),
    .restart(restart), .vol_up(vol_up), .vol_down(vol_down), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_addr(wr_addr), .wr_div(wr_div), .audio_left(l0), .audio_right(r0), .vol(vol0),
    .step_idx(idx0), .done(done0));

  poly_tone_sequencer #(.NUM_CH(2), .SEQ_DEPTH(3), .DIV_W(22), .VOL_W(4), .AMP_UNIT(2500), .STEREO(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .step_tick(step_tick), .play_en(play_en), .loop_mode(loop_mode),
    .restart(restart), .vol_up(vol_up), .vol_down(vol_down), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_addr(wr_addr), .wr_div(wr_div), .audio_left(l1), .audio_right(r1), .vol(vol1),
    .step_idx(idx1), .done(done1));

  poly_tone_sequencer #(.NUM_CH(2), .SEQ_DEPTH(3), .DIV_W(22), .VOL_W(4), .AMP_UNIT(1024), .STEREO(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .step_tick(step_tick), .play_en(play_en), .loop_mode(loop_mode),
    .restart(restart), .vol_up(vol_up), .vol_down(vol_down), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_addr(wr_addr), .wr_div(wr_div), .audio_left(l2), .audio_right(r2), .vol(vol2),
    .step_idx(idx2), .done(done2));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: a note of divisor d started at cycle s with phase p0 is high when
  // p0 ^ floor((k-s)/(d+1)) is odd; outputs show the previous cycle's mix.
  int cyc;
  int m_idx, m_vol, m_done;
  int m_div[2], m_start[2], m_ph0[2];
  int m_tbl[2][3];
  int m_l[3], m_r[3];
  int amps[3] = '{1024, 2500, 1024};

  function automatic int ph(int c, int k);
    if (m_div[c] == 0) return 0;
    return m_ph0[c] ^ (((k - m_start[c]) / (m_div[c] + 1)) & 1);
  endfunction

  function automatic int sat(int x);
    return (x > 32767) ? 32767 : ((x < -32768) ? -32768 : x);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_idx = 0; m_vol = 8; m_done = 0;
      for (int c = 0; c < 2; c++) begin m_div[c] = 0; m_start[c] = 0; m_ph0[c] = 0; end
      for (int i = 0; i < 3; i++) begin m_l[i] = 0; m_r[i] = 0; end
    end else begin
      int s[2];
      int nd[2];
      for (int i = 0; i < 3; i++) begin
        for (int c = 0; c < 2; c++)
          s[c] = (m_div[c] == 0) ? 0 : (ph(c, cyc) ? m_vol * amps[i] : -m_vol * amps[i]);
        m_l[i] = sat((i == 2) ? s[0] : s[0] + s[1]);
        m_r[i] = sat((i == 2) ? s[1] : s[0] + s[1]);
      end
      nd[0] = m_div[0]; nd[1] = m_div[1];
      if (restart) begin
        m_idx = 0; m_done = 0; nd[0] = 0; nd[1] = 0;
      end else if (step_tick && play_en && m_done != 0) begin
        nd[0] = 0; nd[1] = 0;
      end else if (step_tick && play_en) begin
        nd[0] = m_tbl[0][m_idx]; nd[1] = m_tbl[1][m_idx];
        if (m_idx < 2) m_idx++;
        else if (loop_mode) m_idx = 0;
        else m_done = 1;
      end
      for (int c = 0; c < 2; c++) begin
        if (nd[c] != m_div[c]) begin
          m_ph0[c] = (m_div[c] == 0 || nd[c] == 0) ? 0 : ph(c, cyc + 1);
          m_start[c] = cyc + 1;
          m_div[c] = nd[c];
        end
      end
      if (wr_en) m_tbl[wr_ch][wr_addr] = int'(wr_div);
      if (vol_up && !vol_down && m_vol < 15) m_vol++;
      else if (vol_down && !vol_up && m_vol > 0) m_vol--;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("idx0", int'(idx0), m_idx); chk("idx1", int'(idx1), m_idx); chk("idx2", int'(idx2), m_idx);
      chk("done0", int'(done0), m_done); chk("vol0", int'(vol0), m_vol); chk("vol2", int'(vol2), m_vol);
      chk("left0", int'(l0), m_l[0]); chk("right0", int'(r0), m_r[0]);
      chk("left1", int'(l1), m_l[1]); chk("right1", int'(r1), m_r[1]);
      chk("left2", int'(l2), m_l[2]); chk("right2", int'(r2), m_r[2]);
    end
  end

  task automatic step1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step1();
  endtask

  task automatic wr(input int ch, input int a, input int d);
    wr_en = 1; wr_ch = ch[0]; wr_addr = a[1:0]; wr_div = d[21:0];
    step1();
    wr_en = 0;
  endtask

  task automatic tick();
    step_tick = 1;
    step1();
    step_tick = 0;
  endtask

  task automatic do_restart();
    restart = 1;
    step1();
    restart = 0;
  endtask

  initial begin
    wait_n(3);
    rst_n = 1;
    chk("rst_idx", int'(idx0), 0); chk("rst_done", int'(done0), 0); chk("rst_vol", int'(vol0), 8);
    chk("rst_left", int'(l0), 0); chk("rst_right", int'(r0), 0);

    wr(0, 0, 4); wr(0, 1, 0); wr(0, 2, 6);
    wr(1, 0, 0); wr(1, 1, 0); wr(1, 2, 0);

    // Looping playback, ticks every 100 cycles.
    tick();
    step1(); chk("t1_low", int'(l0), -8192); chk("t1_stereo_r", int'(r2), 0);
    wait_n(5); chk("t1_high", int'(l0), 8192); chk("t1_amp2500", int'(l1), 20000);
    wait_n(5); chk("t1_low2", int'(l0), -8192);
    wait_n(88);
    tick(); step1(); chk("t2_rest", int'(l0), 0);
    wait_n(98);
    tick(); chk("t3_wrap_idx", int'(idx0), 0);
    step1(); chk("t3_low", int'(l0), -8192);
    wait_n(7); chk("t3_high", int'(l0), 8192);
    wait_n(91);
    tick(); chk("t4_idx", int'(idx0), 1);
    wait_n(20);
    // Same-cycle write to the slot being read loads the old rest.
    step_tick = 1; wr_en = 1; wr_ch = 0; wr_addr = 1; wr_div = 9;
    step1();
    step_tick = 0; wr_en = 0;
    step1(); chk("rbw_old", int'(l0), 0);

    // One-shot playback.
    do_restart();
    loop_mode = 0;
    tick(); wait_n(20); tick(); wait_n(20); tick();
    chk("os_done", int'(done0), 1); chk("os_idx", int'(idx0), 2);
    wait_n(20);
    chk("os_tone", (l0 < 0) ? -int'(l0) : int'(l0), 8192);
    tick(); step1();
    chk("os_silent", int'(l0), 0); chk("os_idx_hold", int'(idx0), 2); chk("os_done_hold", int'(done0), 1);
    do_restart();
    chk("rs_done", int'(done0), 0); chk("rs_idx", int'(idx0), 0);

    // Pause: tick ignored while the tone keeps going.
    loop_mode = 1;
    tick(); wait_n(3);
    play_en = 0; tick(); chk("pause_idx", int'(idx0), 1);
    wait_n(12); play_en = 1;

    // Volume saturation.
    vol_up = 1; wait_n(10); vol_up = 0;
    chk("vol_max", int'(vol0), 15);
    vol_up = 1; vol_down = 1; step1(); vol_up = 0; vol_down = 0;
    chk("vol_both", int'(vol0), 15);
    vol_down = 1; wait_n(20); vol_down = 0;
    chk("vol_min", int'(vol0), 0);
    wait_n(3); chk("vol0_left", int'(l0), 0); chk("vol0_right1", int'(r1), 0);
    vol_up = 1; wait_n(15); vol_up = 0;

    // Both channels in phase drive the 2500 instance into saturation.
    do_restart();
    wr(0, 0, 5); wr(1, 0, 5);
    tick(); step1();
    chk("sat_neg", int'(l1), -32768); chk("nosat_neg", int'(l0), -30720);
    wait_n(6);
    chk("sat_pos", int'(r1), 32767); chk("nosat_pos", int'(r0), 30720);

    // Only channel 1 sounding: stereo instance puts it on the right.
    do_restart();
    wr(0, 0, 0); wr(1, 0, 3);
    tick(); step1();
    chk("st_left", int'(l2), 0); chk("st_right_low", int'(r2), -15360);
    wait_n(4); chk("st_right_high", int'(r2), 15360);

    // Restart beats a same-cycle tick.
    wait_n(10);
    step_tick = 1; restart = 1; step1(); step_tick = 0; restart = 0;
    chk("rt_idx", int'(idx0), 0);
    step1(); chk("rt_silent", int'(r2), 0);
    wait_n(4); chk("rt_still_silent", int'(r2), 0);

    // Asynchronous reset in the middle of a tone.
    tick(); wait_n(3);
    #2 rst_n = 0;
    #1;
    chk("arst_right2", int'(r2), 0); chk("arst_left0", int'(l0), 0);
    chk("arst_idx", int'(idx0), 0); chk("arst_vol", int'(vol0), 8);
    step1(); rst_n = 1;
    wait_n(5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
